// File: rtl/sonar_scheduler_if.sv
`timescale 1ns/1ps
// Purpose : bundles the sonar scheduler control, pin and result signals.
// Latency : none, wiring only.
// Backpr. : none; the result is a one-cycle valid pulse with no ready.
// Ports   : enable, chan_mask, sonar_echo in; sonar_trig, busy, result_* out.
//           SONAR_SCHEDULER_IRQ_EN adds irq (out) and irq_clear (in).
interface sonar_scheduler_if #(
  parameter int NUM_SONAR = 2
);
  logic                 enable;
  logic [NUM_SONAR-1:0] chan_mask;
  logic [NUM_SONAR-1:0] sonar_trig;
  logic [NUM_SONAR-1:0] sonar_echo;
  logic                 busy;
  logic                 result_valid;
  logic [2:0]           result_chan;
  logic [15:0]          result_us;
  logic                 result_timeout;
`ifdef SONAR_SCHEDULER_IRQ_EN
  logic                 irq;
  logic                 irq_clear;

  modport master (
    input  enable, chan_mask, sonar_echo, irq_clear,
    output sonar_trig, busy, result_valid, result_chan, result_us,
           result_timeout, irq
  );
  modport slave (
    output enable, chan_mask, sonar_echo, irq_clear,
    input  sonar_trig, busy, result_valid, result_chan, result_us,
           result_timeout, irq
  );
`else
  modport master (
    input  enable, chan_mask, sonar_echo,
    output sonar_trig, busy, result_valid, result_chan, result_us,
           result_timeout
  );
  modport slave (
    output enable, chan_mask, sonar_echo,
    input  sonar_trig, busy, result_valid, result_chan, result_us,
           result_timeout
  );
`endif
endinterface

// File: rtl/sonar_scheduler.sv
`timescale 1ns/1ps
// Purpose : round-robin trigger/echo timing for NUM_SONAR rangers, one active at a time.
// Latency : echo pins see 2 clk of synchronizer; timeout report lands 2 clk after the us count hits TIMEOUT_US.
// Backpr. : none; result_valid is a one-cycle pulse, fields hold until the next report.
// Ports   : clk, reset (async, active high); bus (master modport of sonar_scheduler_if).
// Option  : define SONAR_SCHEDULER_IRQ_EN to build the sticky irq flag and irq_clear input.
module sonar_scheduler #(
  parameter int CLK_FREQUENCY = 60_000_000,
  parameter int NUM_SONAR     = 2,
  parameter int TRIG_US       = 10,
  parameter int TIMEOUT_US    = 30000,
  parameter int GAP_US        = 10000
) (
  input  logic              clk,
  input  logic              reset,
  sonar_scheduler_if.master bus
);
  localparam int              DIV       = CLK_FREQUENCY / 1_000_000;
  localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST  = PW'(DIV - 1);
  localparam logic [15:0]     TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0]     GAP_LAST  = 16'(GAP_US - 1);
  localparam logic [15:0]     TIMEOUT_V = 16'(TIMEOUT_US);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GAP
  } state_t;

  state_t               state_q;
  logic [2:0]           ptr_q;
  logic [PW-1:0]        pre_q;
  logic [15:0]          us_q;
  logic                 hit_q;
  logic [NUM_SONAR-1:0] echo_s1_q, echo_s2_q, echo_s3_q;
  logic [NUM_SONAR-1:0] trig_q;
  logic                 busy_q;
  logic                 rv_q;
  logic [2:0]           rchan_q;
  logic [15:0]          rus_q;
  logic                 rto_q;
`ifdef SONAR_SCHEDULER_IRQ_EN
  logic                 irq_q;
`endif

  logic                 us_tick;
  logic [15:0]          us_d;
  logic [2:0]           ptr_d;
  logic [NUM_SONAR-1:0] trig_d;
  logic                 echo_now, echo_prev, echo_rise, echo_fall;

  assign us_tick = (pre_q == PRE_LAST);
  assign us_d    = (us_tick && (us_q != 16'hFFFF)) ? us_q + 16'd1 : us_q;

  // Next set mask bit after the current pointer, wrapping. The descending
  // outer loop lets the nearest candidate win the last assignment.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = NUM_SONAR; i >= 1; i--) begin
      for (int j = 0; j < NUM_SONAR; j++) begin
        if ((j == (int'(ptr_q) + i) % NUM_SONAR) && bus.chan_mask[j]) begin
          ptr_d = 3'(j);
        end
      end
    end
  end

  always_comb begin
    trig_d    = '0;
    echo_now  = 1'b0;
    echo_prev = 1'b0;
    for (int j = 0; j < NUM_SONAR; j++) begin
      if (ptr_d == 3'(j)) trig_d[j] = 1'b1;
      if (ptr_q == 3'(j)) begin
        echo_now  = echo_s2_q[j];
        echo_prev = echo_s3_q[j];
      end
    end
  end

  assign echo_rise = echo_now & ~echo_prev;
  assign echo_fall = ~echo_now & echo_prev;

  // Every state change clears prescaler, us counter and the registered
  // timeout compare so each interval starts from a clean count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'(NUM_SONAR - 1);
      pre_q     <= '0;
      us_q      <= '0;
      hit_q     <= 1'b0;
      echo_s1_q <= '0;
      echo_s2_q <= '0;
      echo_s3_q <= '0;
      trig_q    <= '0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
      rchan_q   <= '0;
      rus_q     <= '0;
      rto_q     <= 1'b0;
`ifdef SONAR_SCHEDULER_IRQ_EN
      irq_q     <= 1'b0;
`endif
    end else begin
      echo_s1_q <= bus.sonar_echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
      rv_q      <= 1'b0;
      pre_q     <= us_tick ? '0 : pre_q + 1'b1;
      us_q      <= us_d;
      // Registered compare keeps the 16-bit comparator off the FSM path.
      hit_q     <= (us_q >= TIMEOUT_V);
`ifdef SONAR_SCHEDULER_IRQ_EN
      // Cleared here first so a report later in this block overrides it.
      if (bus.irq_clear) irq_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.enable && (|bus.chan_mask)) begin
            state_q <= S_SELECT;
            busy_q  <= 1'b1;
            pre_q   <= '0; us_q <= '0; hit_q <= 1'b0;
          end
        end
        S_SELECT: begin
          ptr_q   <= ptr_d;
          trig_q  <= trig_d;
          state_q <= S_TRIG;
          pre_q   <= '0; us_q <= '0; hit_q <= 1'b0;
        end
        S_TRIG: begin
          if (us_tick && (us_q == TRIG_LAST)) begin
            trig_q  <= '0;
            state_q <= S_WAIT_RISE;
            pre_q   <= '0; us_q <= '0; hit_q <= 1'b0;
          end
        end
        S_WAIT_RISE: begin
          if (echo_rise) begin
            state_q <= S_MEASURE;
            pre_q   <= '0; us_q <= '0; hit_q <= 1'b0;
          end else if (hit_q) begin
            rv_q    <= 1'b1;
            rchan_q <= ptr_q;
            rus_q   <= TIMEOUT_V;
            rto_q   <= 1'b1;
`ifdef SONAR_SCHEDULER_IRQ_EN
            irq_q   <= 1'b1;
`endif
            state_q <= S_GAP;
            pre_q   <= '0; us_q <= '0; hit_q <= 1'b0;
          end
        end
        S_MEASURE: begin
          // Edge is checked ahead of timeout so a coincident fall still
          // reports a real width.
          if (echo_fall || hit_q) begin
            rv_q    <= 1'b1;
            rchan_q <= ptr_q;
            rus_q   <= echo_fall ? us_d : TIMEOUT_V;
            rto_q   <= ~echo_fall;
`ifdef SONAR_SCHEDULER_IRQ_EN
            irq_q   <= 1'b1;
`endif
            state_q <= S_GAP;
            pre_q   <= '0; us_q <= '0; hit_q <= 1'b0;
          end
        end
        S_GAP: begin
          if (us_tick && (us_q == GAP_LAST)) begin
            if (bus.enable && (|bus.chan_mask)) begin
              state_q <= S_SELECT;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
            pre_q <= '0; us_q <= '0; hit_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          trig_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sonar_trig     = trig_q;
  assign bus.busy           = busy_q;
  assign bus.result_valid   = rv_q;
  assign bus.result_chan    = rchan_q;
  assign bus.result_us      = rus_q;
  assign bus.result_timeout = rto_q;
`ifdef SONAR_SCHEDULER_IRQ_EN
  assign bus.irq            = irq_q;
`endif
endmodule
